// File: rtl/crash_detect_pkg.sv
// crash_detect_pkg
//   Shared definitions for the collision detector: FSM state type and codes,
//   default life/score geometry and a small state-decode helper.
//   Imported by crash_detect and available to the sprite layers.
package crash_detect_pkg;

    localparam int unsigned CRASH_STATE_WIDTH = 2;
    localparam int unsigned CRASH_LIFE_INIT   = 3;
    localparam int unsigned CRASH_LIFE_WIDTH  = 3;
    localparam int unsigned CRASH_SCORE_WIDTH = 16;

    typedef enum logic [CRASH_STATE_WIDTH-1:0] {
        StIdle   = 2'd0,
        StPlay   = 2'd1,
        StInvinc = 2'd2,
        StOver   = 2'd3
    } crash_state_e;

    // States in which collisions are live.
    function automatic logic crash_active(input crash_state_e s);
        return (s == StPlay) || (s == StInvinc);
    endfunction

endpackage

// File: rtl/crash_detect_vsync_edge.sv
// crash_detect_vsync_edge
//   Registers the active-low vertical sync and emits a one-clock frame-end
//   pulse on its 1->0 transition. Reused by the sprite layers.
// Ports
//   clk_vga   in   pixel clock
//   rst_n     in   asynchronous active-low reset
//   v_sync_i  in   vertical sync, active low
//   fe_o      out  frame-end pulse (combinational from registered previous value)
module crash_detect_vsync_edge (
    input  logic clk_vga,
    input  logic rst_n,
    input  logic v_sync_i,
    output logic fe_o
);

    logic v_sync_q;

    // Reset to the idle (high) level so no edge is seen before a real sync.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            v_sync_q <= 1'b1;
        end else begin
            v_sync_q <= v_sync_i;
        end
    end

    assign fe_o = v_sync_q & ~v_sync_i;

endmodule

// File: rtl/crash_detect.sv
// crash_detect
//   Per-pixel collision detector plus score / life / game-over bookkeeping.
//   Compares enemy, bullet and player alpha flags each pixel and issues
//   registered crash pulses one clock later.
//   Optional feature macro: CRASH_INVINCIBLE_EN builds the INVINC state and
//   frame counter (player collisions masked for INVINC_FRAMES frames after a
//   life loss). Without it a life loss stays in PLAY.
// Ports
//   clk_vga               in   pixel clock
//   rst_n                 in   asynchronous active-low reset
//   en_i                  in   game running (level)
//   v_sync_i              in   vertical sync, active low
//   me_alpha_i            in   player layer opaque
//   bullet_alpha_i        in   bullet layer opaque
//   enemy_alpha_i         in   enemy layer opaque
//   crash_enemy_bullet_o  out  enemy & bullet coincidence, 1 clk latency
//   crash_me_enemy_o      out  enemy & player coincidence, 1 clk latency
//   score_o               out  current score (saturating)
//   life_o                out  remaining lives
//   game_over_o           out  high while in OVER
module crash_detect
    import crash_detect_pkg::*;
#(
    parameter int unsigned LIFE_INIT     = CRASH_LIFE_INIT,
    parameter int unsigned LIFE_WIDTH    = CRASH_LIFE_WIDTH,
    parameter int unsigned SCORE_WIDTH   = CRASH_SCORE_WIDTH,
    parameter int unsigned HIT_SCORE     = 1,
    parameter int unsigned INVINC_FRAMES = 120
) (
    input  logic                   clk_vga,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic                   v_sync_i,
    input  logic                   me_alpha_i,
    input  logic                   bullet_alpha_i,
    input  logic                   enemy_alpha_i,
    output logic                   crash_enemy_bullet_o,
    output logic                   crash_me_enemy_o,
    output logic [SCORE_WIDTH-1:0] score_o,
    output logic [LIFE_WIDTH-1:0]  life_o,
    output logic                   game_over_o
);

    localparam logic [LIFE_WIDTH-1:0]  LifeInit = LIFE_WIDTH'(LIFE_INIT);
    localparam logic [LIFE_WIDTH-1:0]  LifeOne  = LIFE_WIDTH'(1);
    localparam logic [SCORE_WIDTH-1:0] HitScore = SCORE_WIDTH'(HIT_SCORE);

    if (INVINC_FRAMES == 0) begin : g_bad_invinc_frames
        $error("INVINC_FRAMES must be nonzero");
    end

`ifdef CRASH_INVINCIBLE_EN
    localparam int unsigned CntW = (INVINC_FRAMES > 1) ? $clog2(INVINC_FRAMES) : 1;
    localparam logic [CntW-1:0] InvincLast = CntW'(INVINC_FRAMES - 1);
    logic [CntW-1:0] invinc_cnt_q;
`endif

    crash_state_e           state_q;
    logic                   crash_eb_q;
    logic                   crash_me_q;
    logic                   eb_hit_q;
    logic                   me_hit_q;
    logic [SCORE_WIDTH-1:0] score_q;
    logic [LIFE_WIDTH-1:0]  life_q;
    logic                   game_over_q;

    logic fe;
    logic eb_now;
    logic me_now;

    assign eb_now = enemy_alpha_i & bullet_alpha_i;
    assign me_now = enemy_alpha_i & me_alpha_i;

    crash_detect_vsync_edge u_vsync_edge (
        .clk_vga  (clk_vga),
        .rst_n    (rst_n),
        .v_sync_i (v_sync_i),
        .fe_o     (fe)
    );

    function automatic logic [SCORE_WIDTH-1:0] sat_add(input logic [SCORE_WIDTH-1:0] a);
        logic [SCORE_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, HitScore};
        return sum[SCORE_WIDTH] ? '1 : sum[SCORE_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            crash_eb_q  <= 1'b0;
            crash_me_q  <= 1'b0;
            eb_hit_q    <= 1'b0;
            me_hit_q    <= 1'b0;
            score_q     <= '0;
            life_q      <= LifeInit;
            game_over_q <= 1'b0;
`ifdef CRASH_INVINCIBLE_EN
            invinc_cnt_q <= '0;
`endif
        end else begin
            // Player collisions are masked in INVINC; OVER/IDLE mask both.
            crash_eb_q  <= eb_now & crash_active(state_q);
            crash_me_q  <= me_now & (state_q == StPlay);
            game_over_q <= 1'b0;

            if (!en_i) begin
                // Score and life are held for display.
                state_q  <= StIdle;
                eb_hit_q <= 1'b0;
                me_hit_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q  <= StPlay;
                        score_q  <= '0;
                        life_q   <= LifeInit;
                        eb_hit_q <= 1'b0;
                        me_hit_q <= 1'b0;
                    end

                    StPlay: begin
                        // A hit on the fe cycle seeds the next frame's flags.
                        eb_hit_q <= fe ? eb_now : (eb_hit_q | eb_now);
                        me_hit_q <= fe ? me_now : (me_hit_q | me_now);
                        if (fe) begin
                            if (eb_hit_q) begin
                                score_q <= sat_add(score_q);
                            end
                            if (me_hit_q && (life_q != '0)) begin
                                life_q <= life_q - LifeOne;
                                if (life_q == LifeOne) begin
                                    state_q     <= StOver;
                                    game_over_q <= 1'b1;
                                end
`ifdef CRASH_INVINCIBLE_EN
                                else begin
                                    state_q      <= StInvinc;
                                    invinc_cnt_q <= '0;
                                end
`endif
                            end
                        end
                    end

`ifdef CRASH_INVINCIBLE_EN
                    StInvinc: begin
                        eb_hit_q <= fe ? eb_now : (eb_hit_q | eb_now);
                        me_hit_q <= 1'b0;
                        if (fe) begin
                            if (eb_hit_q) begin
                                score_q <= sat_add(score_q);
                            end
                            if (invinc_cnt_q == InvincLast) begin
                                state_q      <= StPlay;
                                invinc_cnt_q <= '0;
                            end else begin
                                invinc_cnt_q <= invinc_cnt_q + CntW'(1);
                            end
                        end
                    end
`endif

                    StOver: begin
                        eb_hit_q    <= 1'b0;
                        me_hit_q    <= 1'b0;
                        game_over_q <= 1'b1;
                    end

                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign crash_enemy_bullet_o = crash_eb_q;
    assign crash_me_enemy_o     = crash_me_q;
    assign score_o              = score_q;
    assign life_o               = life_q;
    assign game_over_o          = game_over_q;

endmodule

// File: tb/tb_crash_detect.sv
module tb_crash_detect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        v_sync;
    logic        me_a;
    logic        bullet_a;
    logic        enemy_a;

    logic        crash_eb;
    logic        crash_me;
    logic [15:0] score;
    logic [2:0]  life;
    logic        go;

    logic        s_crash_eb;
    logic        s_crash_me;
    logic [15:0] s_score;
    logic [2:0]  s_life;
    logic        s_go;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crash_detect dut (
        .clk_vga              (clk),
        .rst_n                (rst_n),
        .en_i                 (en),
        .v_sync_i             (v_sync),
        .me_alpha_i           (me_a),
        .bullet_alpha_i       (bullet_a),
        .enemy_alpha_i        (enemy_a),
        .crash_enemy_bullet_o (crash_eb),
        .crash_me_enemy_o     (crash_me),
        .score_o              (score),
        .life_o               (life),
        .game_over_o          (go)
    );

    // Large increment so saturation at 0xFFFF is reachable in a few frames.
    crash_detect #(.HIT_SCORE(32'h7FFF)) dut_sat (
        .clk_vga              (clk),
        .rst_n                (rst_n),
        .en_i                 (en),
        .v_sync_i             (v_sync),
        .me_alpha_i           (me_a),
        .bullet_alpha_i       (bullet_a),
        .enemy_alpha_i        (enemy_a),
        .crash_enemy_bullet_o (s_crash_eb),
        .crash_me_enemy_o     (s_crash_me),
        .score_o              (s_score),
        .life_o               (s_life),
        .game_over_o          (s_go)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alpha(input logic e, input logic b, input logic m);
        enemy_a  = e;
        bullet_a = b;
        me_a     = m;
    endtask

    task automatic frame_end();
        v_sync = 1'b0;
        step();
        v_sync = 1'b1;
        step();
    endtask

    // Sits out the invincibility window, probing that player hits stay masked.
    task automatic wait_invinc(input int frames);
`ifdef CRASH_INVINCIBLE_EN
        for (int i = 0; i < frames; i++) begin
            set_alpha(1'b1, 1'b0, 1'b1);
            step();
            check("invinc_mask", {31'd0, crash_me}, 32'd0);
            set_alpha(1'b0, 1'b0, 1'b0);
            frame_end();
        end
`else
        if (frames < 0) $display("negative frame count");
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        v_sync = 1'b1;
        set_alpha(1'b0, 1'b0, 1'b0);
        #12;
        check("rst_score", {16'd0, score}, 32'd0);
        check("rst_life", {29'd0, life}, 32'd3);
        check("rst_flags", {29'd0, crash_eb, crash_me, go}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: idle with everything opaque, no pulses for 1000 clocks
        set_alpha(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            step();
            check("idle", {10'd0, crash_eb, crash_me, go, score, life},
                  {10'd0, 3'b000, 16'h0000, 3'd3});
        end
        set_alpha(1'b0, 1'b0, 1'b0);

        // 2: enemy & bullet for 4 clocks
        en = 1'b1;
        step();
        check("start_score", {16'd0, score}, 32'd0);
        check("start_life", {29'd0, life}, 32'd3);
        set_alpha(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("eb_pulse", {30'd0, crash_eb, crash_me}, 32'b10);
        end
        set_alpha(1'b0, 1'b0, 1'b0);
        step();
        check("eb_pulse_end", {31'd0, crash_eb}, 32'd0);
        frame_end();
        check("score_1", {16'd0, score}, 32'd1);

        // 3: 50 player hits in one frame -> one life lost
        set_alpha(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            step();
            check("me_pulse", {30'd0, crash_eb, crash_me}, 32'b01);
        end
        set_alpha(1'b0, 1'b0, 1'b0);
        frame_end();
        check("life_2", {29'd0, life}, 32'd2);
        check("score_hold", {16'd0, score}, 32'd1);
        frame_end();
        check("life_2_once", {29'd0, life}, 32'd2);
        wait_invinc(119);

        // 4: two more life-losing frames -> OVER
        set_alpha(1'b1, 1'b0, 1'b1);
        step();
        check("me_resp", {31'd0, crash_me}, 32'd1);
        set_alpha(1'b0, 1'b0, 1'b0);
        frame_end();
        check("life_1", {29'd0, life}, 32'd1);
        check("go_0", {31'd0, go}, 32'd0);
        wait_invinc(120);
        set_alpha(1'b1, 1'b0, 1'b1);
        step();
        check("me_resp2", {31'd0, crash_me}, 32'd1);
        set_alpha(1'b0, 1'b0, 1'b0);
        v_sync = 1'b0;
        step();
        check("life_0", {29'd0, life}, 32'd0);
        check("go_1", {31'd0, go}, 32'd1);
        v_sync = 1'b1;
        step();
        set_alpha(1'b1, 1'b1, 1'b1);
        step();
        step();
        check("over_mask", {30'd0, crash_eb, crash_me}, 32'd0);
        set_alpha(1'b0, 1'b0, 1'b0);
        frame_end();
        check("over_frozen", {13'd0, go, score, life}, {13'd0, 1'b1, 16'd1, 3'd0});
        en = 1'b0;
        step();
        check("idle_hold", {13'd0, go, score, life}, {13'd0, 1'b0, 16'd1, 3'd0});
        en = 1'b1;
        step();
        check("restart", {13'd0, go, score, life}, {13'd0, 1'b0, 16'd0, 3'd3});

        // 5: coincidence on the fe cycle counts toward the next frame
        set_alpha(1'b1, 1'b1, 1'b0);
        v_sync = 1'b0;
        step();
        check("fe_hit_pulse", {31'd0, crash_eb}, 32'd1);
        check("fe_hit_not_now", {16'd0, score}, 32'd0);
        set_alpha(1'b0, 1'b0, 1'b0);
        v_sync = 1'b1;
        step();
        frame_end();
        check("fe_hit_next", {16'd0, score}, 32'd1);
        check("sat_7fff", {16'd0, s_score}, 32'h7FFF);
        set_alpha(1'b1, 1'b1, 1'b0);
        step();
        set_alpha(1'b0, 1'b0, 1'b0);
        frame_end();
        check("score_2", {16'd0, score}, 32'd2);
        check("sat_fffe", {16'd0, s_score}, 32'hFFFE);
        set_alpha(1'b1, 1'b1, 1'b0);
        step();
        set_alpha(1'b0, 1'b0, 1'b0);
        frame_end();
        check("sat_ffff", {16'd0, s_score}, 32'hFFFF);
        set_alpha(1'b1, 1'b1, 1'b0);
        step();
        set_alpha(1'b0, 1'b0, 1'b0);
        frame_end();
        check("score_4", {16'd0, score}, 32'd4);
        check("sat_stay", {16'd0, s_score}, 32'hFFFF);

        // 6: asynchronous reset mid-frame with flags set
        set_alpha(1'b1, 1'b1, 1'b1);
        step();
        check("pre_rst_eb", {30'd0, crash_eb, crash_me}, 32'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {10'd0, crash_eb, crash_me, go, score, life},
              {10'd0, 3'b000, 16'h0000, 3'd3});
        set_alpha(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst", {10'd0, crash_eb, crash_me, go, score, life},
              {10'd0, 3'b000, 16'h0000, 3'd3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
